mem_req_noc_arb: RTL
====================

// Module: mem_req_noc_arb
// PURPOSE
//  Synchronous N-to-1 memory-request interconnect: NUM_CH upstream requesters, each with
//  its own request FIFO, share one downstream memory port through a round-robin arbiter.
//  Every downstream request returns exactly one in-order response, which is routed back
//  to the issuing channel via an order FIFO of channel IDs. Sits between core/DMA masters
//  and the single mem port, on the same side of any CDC bridge.
// PARAMETERS
//  NUM_CH   4   number of upstream channels (2..16)
//  REQ_W    64  request payload width (packed mem request: addr/data/strb/we)
//  RSP_W    32  response payload width
//  DEPTH    4   entries per channel request FIFO (power of 2, >=2)
//  MAX_OST  8   max granted-but-unanswered requests (power of 2, >=1)
//  CH_W     $clog2(NUM_CH) (localparam, min 1)
// PORTS
//  clk           in   1            clock
//  rstn          in   1            asynchronous active-low reset
//  up_req_valid  in   NUM_CH       per-channel request valid
//  up_req_ready  out  NUM_CH       per-channel request ready (= FIFO not full)
//  up_req        in   NUM_CH*REQ_W channel c payload at [c*REQ_W +: REQ_W]
//  up_rsp_valid  out  NUM_CH       per-channel response valid
//  up_rsp_ready  in   NUM_CH       per-channel response ready
//  up_rsp        out  RSP_W        response payload (shared; qualify with up_rsp_valid)
//  dn_req_valid  out  1            downstream request valid (registered)
//  dn_req_ready  in   1            downstream request ready
//  dn_req        out  REQ_W        downstream request payload (registered)
//  dn_req_ch     out  CH_W         channel ID of current dn_req
//  dn_rsp_valid  in   1            downstream response valid
//  dn_rsp_ready  out  1            downstream response ready
//  dn_rsp        in   RSP_W        downstream response payload
//  ost_cnt       out  $clog2(MAX_OST)+1  outstanding request count
//  err_unexp_rsp out  1            sticky: dn_rsp_valid seen with order FIFO empty
// BEHAVIOUR
//  - Reset (async assert, sync release): all FIFOs empty, RR pointer=0, ost_cnt=0;
//    dn_req_valid=0, dn_req=0, dn_req_ch=0, up_rsp_valid=0, err_unexp_rsp=0.
//    up_req_ready=all-1 from first cycle after release. Reset mid-op drops all state.
//  - Handshakes valid/ready; valid must not depend on ready. Transfer when both high.
//  - Upstream write: c pushes on up_req_valid[c]&up_req_ready[c]; ready = !full[c].
//  - Issue: output reg "free" = !dn_req_valid | dn_req_ready. When free and
//    ost_cnt<MAX_OST, arbiter grants first non-empty channel at/after RR pointer
//    (wrapping NUM_CH-1 -> 0); head popped into dn_req/dn_req_ch, dn_req_valid=1,
//    channel ID pushed to order FIFO, RR pointer = grant+1 (mod NUM_CH).
//    No grant -> pointer unchanged; dn_req_valid drops if reg was accepted.
//  - Latency: up_req accepted in cycle t into an idle block -> dn_req_valid in t+2.
//    Sustained throughput 1 req/cycle when dn_req_ready=1 and ost limit not hit.
//  - ost_cnt: +1 on grant, -1 on dn_rsp handshake; both same cycle -> unchanged.
//    ost_cnt==MAX_OST blocks grant even if a response pops that cycle.
//  - Response: head = order FIFO head ch h. up_rsp=dn_rsp;
//    up_rsp_valid[h]=dn_rsp_valid & !order_empty, other bits 0;
//    dn_rsp_ready = !order_empty & up_rsp_ready[h]. Pop order FIFO on dn_rsp handshake.
//  - Order FIFO empty and dn_rsp_valid=1: dn_rsp_ready=0, err_unexp_rsp set (sticky to reset).
//  - A channel whose FIFO fills keeps ready low; other channels unaffected.
// TESTING
//  1 Single req ch2 payload 'h1 at t, dn_req_ready=1 -> dn_req='h1, dn_req_ch=2 at t+2;
//    dn_rsp 'hAA -> up_rsp_valid=4'b0100, up_rsp='hAA, ost_cnt 1->0.
//  2 All 4 ch push 'h1..'hf continuously, dn_req_ready=1, rsp immediate -> dn_req_ch
//    sequence 0,1,2,3,0,1.. and per-channel payload order preserved.
//  3 dn_req_ready=0 for 10 cycles, ch0 pushes -> up_req_ready[0] low after 4+1 accepts
//    (FIFO + out reg); dn_req stable while stalled.
//  4 No responses, MAX_OST=8 -> exactly 8 grants, ost_cnt=8, dn_req_valid then 0;
//    one response -> one more grant.
//  5 up_rsp_ready[h]=0 -> dn_rsp_ready=0, response held; dn_rsp_valid w/ ost_cnt=0 ->
//    err_unexp_rsp=1.
//  6 rstn low mid-traffic -> all outputs to reset values same cycle, queued reqs lost.

Source files
------------

// File: rtl/mem_req_noc_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_noc_arb
// Description : N-to-1 memory request interconnect. Per-channel request FIFOs
//               feed a round-robin arbiter driving one registered downstream
//               request port. In-order responses are routed back to the
//               issuing channel through an order FIFO of channel IDs.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_noc_arb #(
  parameter int NUM_CH  = 4,
  parameter int REQ_W   = 64,
  parameter int RSP_W   = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OST = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int OST_W  = $clog2(MAX_OST) + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_CH-1:0]       up_req_valid,
  output logic [NUM_CH-1:0]       up_req_ready,
  input  logic [NUM_CH*REQ_W-1:0] up_req,
  output logic [NUM_CH-1:0]       up_rsp_valid,
  input  logic [NUM_CH-1:0]       up_rsp_ready,
  output logic [RSP_W-1:0]        up_rsp,
  output logic                    dn_req_valid,
  input  logic                    dn_req_ready,
  output logic [REQ_W-1:0]        dn_req,
  output logic [CH_W-1:0]         dn_req_ch,
  input  logic                    dn_rsp_valid,
  output logic                    dn_rsp_ready,
  input  logic [RSP_W-1:0]        dn_rsp,
  output logic [OST_W-1:0]        ost_cnt,
  output logic                    err_unexp_rsp
);

  localparam int AW     = $clog2(DEPTH);
  // Order FIFO needs at least MAX_OST entries; keep a 1-bit index minimum.
  localparam int OAW    = (MAX_OST > 1) ? $clog2(MAX_OST) : 1;
  localparam int ODEPTH = 1 << OAW;

  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_full;
  logic [REQ_W-1:0]  w_head [NUM_CH];

  logic              w_cand_vld;
  logic [CH_W-1:0]   w_grant_ch;
  logic [CH_W:0]     w_sum;
  logic              w_free;
  logic              w_ost_ok;
  logic              w_grant_vld;
  logic [CH_W-1:0]   w_rr_next;

  logic [CH_W-1:0]   r_rr_ptr;
  logic              r_dn_req_valid;
  logic [REQ_W-1:0]  r_dn_req;
  logic [CH_W-1:0]   r_dn_req_ch;
  logic [OST_W-1:0]  r_ost_cnt;
  logic              r_err;

  logic [CH_W-1:0]   r_ord_mem [ODEPTH];
  logic [OAW:0]      r_ord_wptr;
  logic [OAW:0]      r_ord_rptr;
  logic              w_ord_empty;
  logic [CH_W-1:0]   w_ord_head;
  logic              w_rsp_hs;

  // Per-channel request FIFOs (extra pointer bit distinguishes full from empty)
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [REQ_W-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign w_empty[c] = (r_wptr == r_rptr);
    assign w_full[c]  = (r_wptr[AW] != r_rptr[AW]) &&
                        (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push     = up_req_valid[c] & ~w_full[c];
    assign w_pop      = w_grant_vld && (w_grant_ch == CH_W'(c));
    assign w_head[c]  = r_mem[r_rptr[AW-1:0]];

    // FIFO pointer update
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
        if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= up_req[c*REQ_W +: REQ_W];
    end
  end

  assign up_req_ready = ~w_full;

  // Round-robin search: first non-empty channel at or after the pointer
  always_comb begin
    w_cand_vld = 1'b0;
    w_grant_ch = '0;
    w_sum      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (CH_W+1)'(i);
      if (w_sum >= (CH_W+1)'(NUM_CH)) w_sum = w_sum - (CH_W+1)'(NUM_CH);
      if (!w_cand_vld && !w_empty[w_sum[CH_W-1:0]]) begin
        w_cand_vld = 1'b1;
        w_grant_ch = w_sum[CH_W-1:0];
      end
    end
  end

  assign w_free      = ~r_dn_req_valid | dn_req_ready;
  assign w_ost_ok    = (r_ost_cnt < OST_W'(MAX_OST));
  assign w_grant_vld = w_cand_vld & w_free & w_ost_ok;
  assign w_rr_next   = (w_grant_ch == CH_W'(NUM_CH - 1)) ? '0 : w_grant_ch + CH_W'(1);

  // Arbiter pointer advances past the granted channel only on a grant
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            r_rr_ptr <= '0;
    else if (w_grant_vld) r_rr_ptr <= w_rr_next;
  end

  // Downstream output register: load on grant, drop valid once accepted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dn_req_valid <= 1'b0;
      r_dn_req       <= '0;
      r_dn_req_ch    <= '0;
    end else if (w_grant_vld) begin
      r_dn_req_valid <= 1'b1;
      r_dn_req       <= w_head[w_grant_ch];
      r_dn_req_ch    <= w_grant_ch;
    end else if (dn_req_ready) begin
      r_dn_req_valid <= 1'b0;
    end
  end

  assign dn_req_valid = r_dn_req_valid;
  assign dn_req       = r_dn_req;
  assign dn_req_ch    = r_dn_req_ch;

  assign w_ord_empty = (r_ord_wptr == r_ord_rptr);
  assign w_ord_head  = r_ord_mem[r_ord_rptr[OAW-1:0]];
  assign w_rsp_hs    = dn_rsp_valid & dn_rsp_ready;

  // Order FIFO pointers: push granted channel, pop on response handshake
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ord_wptr <= '0;
      r_ord_rptr <= '0;
    end else begin
      if (w_grant_vld) r_ord_wptr <= r_ord_wptr + (OAW+1)'(1);
      if (w_rsp_hs)    r_ord_rptr <= r_ord_rptr + (OAW+1)'(1);
    end
  end

  // Order FIFO storage write
  always_ff @(posedge clk) begin
    if (w_grant_vld) r_ord_mem[r_ord_wptr[OAW-1:0]] <= w_grant_ch;
  end

  // Route the response to the channel at the head of the order FIFO
  always_comb begin
    up_rsp_valid = '0;
    if (dn_rsp_valid && !w_ord_empty) up_rsp_valid[w_ord_head] = 1'b1;
  end

  assign up_rsp       = dn_rsp;
  assign dn_rsp_ready = ~w_ord_empty & up_rsp_ready[w_ord_head];

  // Outstanding counter: grant and response in the same cycle cancel out
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ost_cnt <= '0;
    end else begin
      case ({w_grant_vld, w_rsp_hs})
        2'b10:   r_ost_cnt <= r_ost_cnt + OST_W'(1);
        2'b01:   r_ost_cnt <= r_ost_cnt - OST_W'(1);
        default: r_ost_cnt <= r_ost_cnt;
      endcase
    end
  end

  // Sticky flag for a response arriving with nothing outstanding
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            r_err <= 1'b0;
    else if (dn_rsp_valid && w_ord_empty) r_err <= 1'b1;
  end

  assign ost_cnt       = r_ost_cnt;
  assign err_unexp_rsp = r_err;

endmodule
`default_nettype wire
